// File: rtl/slurm16_lsu_pkg.sv
// Shared encodings for the slurm16 load/store responder: FSM states, request ops,
// timeout defaults and small op-decoding helpers.
package slurm16_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    OP_MEM_RD = 2'd0,
    OP_MEM_WR = 2'd1,
    OP_IO_RD  = 2'd2,
    OP_IO_WR  = 2'd3
  } lsu_op_t;

  localparam int unsigned LSU_DEFAULT_TIMEOUT_CYCLES = 255;

  // A timed-out read returns every data bit set to this value.
  localparam logic LSU_TIMEOUT_RD_FILL = 1'b1;

  function automatic logic op_is_write(input lsu_op_t op);
    return (op == OP_MEM_WR) || (op == OP_IO_WR);
  endfunction

  function automatic logic op_is_io(input lsu_op_t op);
    return (op == OP_IO_RD) || (op == OP_IO_WR);
  endfunction

endpackage

// File: rtl/slurm16_bus_timeout_counter.sv
// Bus-wait counter for the load/store responder; built only with SLURM16_BUS_TIMEOUT_EN.
// expired is high in the BUS cycle that would bring the wait count to TIMEOUT_CYCLES.
module slurm16_bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_BITS   = 8
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_BITS-1:0] LAST_COUNT = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_BITS-1:0] count_r;

  // Count ack-less bus cycles; saturates at the last count so it never wraps.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      count_r <= {TIMEOUT_BITS{1'b0}};
    end else if (clear) begin
      count_r <= {TIMEOUT_BITS{1'b0}};
    end else if (count_en && (count_r != LAST_COUNT)) begin
      count_r <= count_r + TIMEOUT_BITS'(1);
    end
  end

  assign expired = count_en && (count_r == LAST_COUNT);

endmodule

// File: rtl/slurm16_load_store_responder.sv
// slurm16 load/store responder: runs one execute-stage memory or port request on the
// shared req/ack bus and stalls until it completes. SLURM16_BUS_TIMEOUT_EN adds a wait timeout.
module slurm16_load_store_responder
  import slurm16_lsu_pkg::*;
#(
  parameter int unsigned BITS           = 16,
  parameter int unsigned ADDRESS_BITS   = 16,
  parameter int unsigned TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TIMEOUT_BITS   = 8
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    load_memory,
  input  logic                    store_memory,
  input  logic [ADDRESS_BITS-1:0] load_store_address,
  input  logic [BITS-1:0]         memory_out,
  input  logic                    port_rd,
  input  logic                    port_wr,
  input  logic [ADDRESS_BITS-1:0] port_address,
  input  logic [BITS-1:0]         port_out,
  output logic                    stall,
  output logic [BITS-1:0]         rd_data,
  output logic                    rd_valid,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic                    bus_io,
  output logic [ADDRESS_BITS-1:0] bus_addr,
  output logic [BITS-1:0]         bus_wdata,
  input  logic                    bus_ack,
  input  logic [BITS-1:0]         bus_rdata,
  output logic                    bus_error
);

  lsu_state_t              state_r;
  lsu_op_t                 sel_op_s;
  logic [ADDRESS_BITS-1:0] sel_addr_s;
  logic [BITS-1:0]         sel_wdata_s;
  logic                    any_req_s;
  logic                    bus_req_r;
  logic                    bus_we_r;
  logic                    bus_io_r;
  logic [ADDRESS_BITS-1:0] bus_addr_r;
  logic [BITS-1:0]         bus_wdata_r;
  logic [BITS-1:0]         rd_data_r;
  logic                    rd_valid_r;

  assign any_req_s = store_memory | load_memory | port_wr | port_rd;

  // Pick one request; lower-priority requests in the same cycle are dropped.
  always_comb begin
    sel_op_s    = OP_MEM_RD;
    sel_addr_s  = load_store_address;
    sel_wdata_s = memory_out;
    if (store_memory) begin
      sel_op_s = OP_MEM_WR;
    end else if (load_memory) begin
      sel_op_s = OP_MEM_RD;
    end else if (port_wr) begin
      sel_op_s    = OP_IO_WR;
      sel_addr_s  = port_address;
      sel_wdata_s = port_out;
    end else if (port_rd) begin
      sel_op_s    = OP_IO_RD;
      sel_addr_s  = port_address;
      sel_wdata_s = port_out;
    end else begin
      sel_op_s = OP_MEM_RD;
    end
  end

`ifdef SLURM16_BUS_TIMEOUT_EN
  logic timeout_s;
  logic bus_error_r;

  slurm16_bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_BITS   (TIMEOUT_BITS)
  ) u_timeout (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .clear    (state_r != ST_BUS),
    .count_en ((state_r == ST_BUS) && !bus_ack),
    .expired  (timeout_s)
  );

  // Error pulse lands in the DONE cycle that follows a timed-out BUS cycle.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      bus_error_r <= 1'b0;
    end else begin
      bus_error_r <= timeout_s;
    end
  end

  assign bus_error = bus_error_r;
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = ^{TIMEOUT_CYCLES, TIMEOUT_BITS};
  assign bus_error = 1'b0;
`endif

  // Request FSM: latch in IDLE, hold the bus in BUS, retire in DONE.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_r     <= ST_IDLE;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_io_r    <= 1'b0;
      bus_addr_r  <= {ADDRESS_BITS{1'b0}};
      bus_wdata_r <= {BITS{1'b0}};
      rd_data_r   <= {BITS{1'b0}};
      rd_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rd_valid_r <= 1'b0;
          if (any_req_s) begin
            state_r     <= ST_BUS;
            bus_req_r   <= 1'b1;
            bus_we_r    <= op_is_write(sel_op_s);
            bus_io_r    <= op_is_io(sel_op_s);
            bus_addr_r  <= sel_addr_s;
            bus_wdata_r <= sel_wdata_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            state_r   <= ST_DONE;
            bus_req_r <= 1'b0;
            if (!bus_we_r) begin
              rd_data_r  <= bus_rdata;
              rd_valid_r <= 1'b1;
            end
          end
`ifdef SLURM16_BUS_TIMEOUT_EN
          else if (timeout_s) begin
            state_r   <= ST_DONE;
            bus_req_r <= 1'b0;
            if (!bus_we_r) begin
              rd_data_r  <= {BITS{LSU_TIMEOUT_RD_FILL}};
              rd_valid_r <= 1'b1;
            end
          end
`endif
          else begin
            state_r <= ST_BUS;
          end
        end
        // Requests seen here belong to the instruction that is retiring now.
        ST_DONE: begin
          rd_valid_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          bus_req_r  <= 1'b0;
          rd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = (state_r == ST_BUS) || ((state_r == ST_IDLE) && any_req_s);
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_io    = bus_io_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_slurm16_load_store_responder.sv
// Scoreboard bench for slurm16_load_store_responder: expected bus transactions and read
// results are queued when a request is driven and compared as the DUT produces them.
module tb_slurm16_load_store_responder;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        load_memory = 1'b0;
  logic        store_memory = 1'b0;
  logic [15:0] load_store_address = 16'h0000;
  logic [15:0] memory_out = 16'h0000;
  logic        port_rd = 1'b0;
  logic        port_wr = 1'b0;
  logic [15:0] port_address = 16'h0000;
  logic [15:0] port_out = 16'h0000;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        bus_req;
  logic        bus_we;
  logic        bus_io;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = 16'h0000;
  logic        bus_error;

  slurm16_load_store_responder #(
    .BITS           (16),
    .ADDRESS_BITS   (16),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_BITS   (8)
  ) dut (
    .CLK                (CLK),
    .RSTb               (RSTb),
    .load_memory        (load_memory),
    .store_memory       (store_memory),
    .load_store_address (load_store_address),
    .memory_out         (memory_out),
    .port_rd            (port_rd),
    .port_wr            (port_wr),
    .port_address       (port_address),
    .port_out           (port_out),
    .stall              (stall),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_io             (bus_io),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_ack            (bus_ack),
    .bus_rdata          (bus_rdata),
    .bus_error          (bus_error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic        io;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_txn_t;

  bus_txn_t    exp_bus_q[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] rd_model = 16'h0000;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic pw, input logic pr,
                           input logic [15:0] la, input logic [15:0] mo,
                           input logic [15:0] pa, input logic [15:0] po);
    load_memory        = ld;
    store_memory       = st;
    port_wr            = pw;
    port_rd            = pr;
    load_store_address = la;
    memory_out         = mo;
    port_address       = pa;
    port_out           = po;
  endtask

  task automatic clear_req();
    load_memory  = 1'b0;
    store_memory = 1'b0;
    port_wr      = 1'b0;
    port_rd      = 1'b0;
  endtask

  task automatic expect_txn(input logic we, input logic io, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit is_rd, input logic [15:0] rdata);
    bus_txn_t t;
    t.we = we; t.io = io; t.addr = addr; t.wdata = wdata;
    exp_bus_q.push_back(t);
    if (is_rd) exp_rd_q.push_back(rdata);
  endtask

  // Called just after a rising edge with the request already driven (cycle 0).
  task automatic service(input string tag, input int waits, input logic [15:0] rdata,
                         input bit hold, input int exp_stall, input int exp_bus_cycles,
                         input logic exp_err);
    int       stall_cnt = 0;
    int       seen = 0;
    bit       done = 1'b0;
    bus_txn_t t;
    t = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge CLK);
      if (stall) stall_cnt++;
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          check_val({tag, "_spurious_rd_valid"}, 64'd1, 64'd0);
        end else begin
          rd_model = exp_rd_q.pop_front();
          check_val({tag, "_rd_data"}, rd_data, rd_model);
        end
      end
      bus_ack = 1'b0;
      if (bus_req) begin
        if (seen == 0) begin
          if (exp_bus_q.size() == 0) begin
            check_val({tag, "_spurious_bus_req"}, 64'd1, 64'd0);
          end else begin
            t = exp_bus_q.pop_front();
            check_val({tag, "_bus_we"}, bus_we, t.we);
            check_val({tag, "_bus_io"}, bus_io, t.io);
            check_val({tag, "_bus_addr"}, bus_addr, t.addr);
            check_val({tag, "_bus_wdata"}, bus_wdata, t.wdata);
          end
          if (!hold) clear_req();
        end else begin
          check_val({tag, "_bus_stable"}, {bus_we, bus_io, bus_addr, bus_wdata}, t);
        end
        if (seen == waits) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
        seen++;
      end else if (seen > 0) begin
        done = 1'b1;
        check_val({tag, "_bus_error"}, bus_error, exp_err);
        check_val({tag, "_rd_data_hold"}, rd_data, rd_model);
        if (hold) clear_req();
      end
    end
    if (!done) check_val({tag, "_no_completion"}, 64'd0, 64'd1);
    check_val({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    check_val({tag, "_bus_cycles"}, seen, exp_bus_cycles);
    check_val({tag, "_rd_pending"}, exp_rd_q.size(), 64'd0);
    @(negedge CLK);
    check_val({tag, "_after_idle"}, {rd_valid, bus_req, bus_error, stall}, 4'b0000);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check_val("reset_ctrl", {stall, bus_req, bus_we, bus_io, rd_valid, bus_error}, 6'b000000);
    check_val("reset_data", {bus_addr, bus_wdata, rd_data}, 48'h0);
    @(posedge CLK); #1;
    RSTb = 1'b1;
    @(posedge CLK); #1;

    // Memory load, ack in the first BUS cycle
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1111, 16'h0000, 16'h0000);
    expect_txn(1'b0, 1'b0, 16'h1234, 16'h1111, 1'b1, 16'hBEEF);
    service("t1_load", 0, 16'hBEEF, 1'b0, 2, 1, 1'b0);

    // Port write with 5 wait cycles; rd_data must keep 0xBEEF
    drive_req(1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 16'h2222, 16'h0042, 16'h00A5);
    expect_txn(1'b1, 1'b1, 16'h0042, 16'h00A5, 1'b0, 16'h0000);
    service("t2_port_wr", 5, 16'h0000, 1'b0, 7, 6, 1'b0);

    // Store beats a simultaneous port read
    drive_req(1'b0, 1'b1, 1'b0, 1'b1, 16'h2000, 16'hCAFE, 16'h0099, 16'h3333);
    expect_txn(1'b1, 1'b0, 16'h2000, 16'hCAFE, 1'b0, 16'h0000);
    service("t3_store_vs_port_rd", 1, 16'h0000, 1'b0, 3, 2, 1'b0);

    // Load beats a simultaneous port write
    drive_req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC, 16'h4444, 16'h0077, 16'h5555);
    expect_txn(1'b0, 1'b0, 16'h0ABC, 16'h4444, 1'b1, 16'h1357);
    service("t3b_load_vs_port_wr", 2, 16'h1357, 1'b0, 4, 3, 1'b0);

    // Port read alone
    drive_req(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0055, 16'h7777);
    expect_txn(1'b0, 1'b1, 16'h0055, 16'h7777, 1'b1, 16'h5A5A);
    service("t3c_port_rd", 0, 16'h5A5A, 1'b0, 2, 1, 1'b0);

    // Request held through DONE must produce exactly one transaction
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h00F0, 16'h0000, 16'h0000, 16'h0000);
    expect_txn(1'b0, 1'b0, 16'h00F0, 16'h0000, 1'b1, 16'h0F0F);
    service("t4_held_req", 0, 16'h0F0F, 1'b1, 2, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_val("t4_no_second_txn", {bus_req, stall, rd_valid}, 3'b000);
    end

    // Stray ack while idle is ignored
    @(negedge CLK);
    bus_ack   = 1'b1;
    bus_rdata = 16'hDEAD;
    @(negedge CLK);
    bus_ack = 1'b0;
    check_val("stray_ack_idle", {bus_req, rd_valid, stall}, 3'b000);
    @(negedge CLK);
    check_val("stray_ack_rd_data", {rd_valid, rd_data}, {1'b0, rd_model});
    @(posedge CLK); #1;

`ifdef SLURM16_BUS_TIMEOUT_EN
    // Load with no ack times out after 4 BUS cycles
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h0000, 16'h0000);
    expect_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'hFFFF);
    service("t6_timeout", 1000, 16'h0000, 1'b0, 5, 4, 1'b1);
`endif

    // Reset during BUS abandons the access
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0777, 16'h0000, 16'h0000, 16'h0000);
    expect_txn(1'b0, 1'b0, 16'h0777, 16'h0000, 1'b0, 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    check_val("t5_bus_req_before_rst", bus_req, 1'b1);
    if (exp_bus_q.size() != 0) begin
      bus_txn_t t;
      t = exp_bus_q.pop_front();
      check_val("t5_bus_addr", bus_addr, t.addr);
    end
    clear_req();
    #2;
    RSTb = 1'b0;
    #1;
    check_val("t5_async_drop", {bus_req, stall, rd_valid}, 3'b000);
    rd_model = 16'h0000;
    check_val("t5_rd_data_cleared", rd_data, rd_model);
    #3;
    RSTb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_val("t5_quiet_after_rst", {bus_req, rd_valid, stall}, 3'b000);
    end
    @(posedge CLK); #1;

    // Normal operation resumes after reset
    drive_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h4444, 16'h8888, 16'h0000, 16'h0000);
    expect_txn(1'b1, 1'b0, 16'h4444, 16'h8888, 1'b0, 16'h0000);
    service("t5b_store_after_rst", 0, 16'h0000, 1'b0, 2, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
